memory_arbiter: RTL

// - Shares the memory's read/write data port between two requesters: CPU data

---
 rtl/memory_arbiter_if.sv | 57 +++++
 rtl/memory_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// +---------------------------------------------------------------------------+
// | Module   : memory_arbiter_if                                              |
// | Brief    : CPU / debug requester ports and memory data port bundle.       |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // CPU data-side requester
  logic                  i_cpu_req;
  logic                  i_cpu_we;
  logic [ADDR_WIDTH-1:0] i_cpu_addr;
  logic [DATA_WIDTH-1:0] i_cpu_wdata;
  logic                  o_cpu_gnt;
  logic                  o_cpu_rvalid;
  // Debug / program loader requester
  logic                  i_dbg_req;
  logic                  i_dbg_we;
  logic [ADDR_WIDTH-1:0] i_dbg_addr;
  logic [DATA_WIDTH-1:0] i_dbg_wdata;
  logic                  o_dbg_gnt;
  logic                  o_dbg_rvalid;
  // Shared read return and memory data port
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_m_valid;
  logic                  o_m_we;
  logic [ADDR_WIDTH-1:0] o_m_addr;
  logic [DATA_WIDTH-1:0] o_m_wdata;
  logic [DATA_WIDTH-1:0] i_m_rdata;
  logic [CNT_WIDTH-1:0]  o_busy_cnt;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_gnt, o_cpu_rvalid,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    output o_dbg_gnt, o_dbg_rvalid,
    output o_rdata, o_m_valid, o_m_we, o_m_addr, o_m_wdata,
    input  i_m_rdata,
    output o_busy_cnt
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_gnt, o_cpu_rvalid,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    input  o_dbg_gnt, o_dbg_rvalid,
    input  o_rdata, o_m_valid, o_m_we, o_m_addr, o_m_wdata,
    output i_m_rdata,
    input  o_busy_cnt
  );
endinterface

`default_nettype wire

// File: rtl/memory_arbiter.sv
// +---------------------------------------------------------------------------+
// | Module   : memory_arbiter                                                 |
// | Brief    : Round-robin arbiter sharing the memory data port between the   |
// |            CPU (port 0) and debug loader (port 1). Optional debug lock    |
// |            enabled by defining HEX_ARB_DBG_LOCK_EN.                       |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module memory_arbiter #(
  parameter int PRIO_RESET = 0,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic i_clk,
  input  wire logic i_rst_n,
`ifdef HEX_ARB_DBG_LOCK_EN
  input  wire logic i_dbg_lock,
`endif
  memory_arbiter_if.slave bus
);

  localparam logic [1:0] c_idle      = 2'd0;
  localparam logic [1:0] c_issue_cpu = 2'd1;
  localparam logic [1:0] c_issue_dbg = 2'd2;

  // Pointer holds the last winner; resetting it to the opposite of
  // PRIO_RESET hands the first tie to PRIO_RESET.
  localparam logic c_last_rst = (PRIO_RESET == 0) ? 1'b1 : 1'b0;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_last;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_cpu_rvalid;
  logic                  r_dbg_rvalid;
  logic [CNT_WIDTH-1:0]  r_busy_cnt;

  logic                  w_cpu_gnt;
  logic                  w_dbg_gnt;
  logic                  w_m_valid;
  logic                  w_cpu_lock;
  logic                  w_cpu_elig;
  logic                  w_dbg_elig;

`ifdef HEX_ARB_DBG_LOCK_EN
  assign w_cpu_lock = i_dbg_lock;
`else
  assign w_cpu_lock = 1'b0;
`endif

  // A requester still holding req during its own grant cycle is not re-accepted.
  assign w_cpu_elig = bus.i_cpu_req & ~w_cpu_gnt & ~w_cpu_lock;
  assign w_dbg_elig = bus.i_dbg_req & ~w_dbg_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = c_idle;
    if (w_cpu_elig && w_dbg_elig) begin
      w_state_nxt = r_last ? c_issue_cpu : c_issue_dbg;
    end else if (w_cpu_elig) begin
      w_state_nxt = c_issue_cpu;
    end else if (w_dbg_elig) begin
      w_state_nxt = c_issue_dbg;
    end
  end

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    w_m_valid = 1'b0;
    case (r_state)
      c_issue_cpu: begin
        w_cpu_gnt = 1'b1;
        w_m_valid = 1'b1;
      end
      c_issue_dbg: begin
        w_dbg_gnt = 1'b1;
        w_m_valid = 1'b1;
      end
      default: begin
        w_m_valid = 1'b0;
      end
    endcase
  end

  // Command register and round-robin pointer load only when someone wins,
  // so the memory port holds its last command while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last  <= c_last_rst;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_state_nxt == c_issue_cpu) begin
      r_last  <= 1'b0;
      r_we    <= bus.i_cpu_we;
      r_addr  <= bus.i_cpu_addr;
      r_wdata <= bus.i_cpu_wdata;
    end else if (w_state_nxt == c_issue_dbg) begin
      r_last  <= 1'b1;
      r_we    <= bus.i_dbg_we;
      r_addr  <= bus.i_dbg_addr;
      r_wdata <= bus.i_dbg_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata      <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_busy_cnt   <= '0;
    end else begin
      if (w_m_valid && !r_we) begin
        r_rdata <= bus.i_m_rdata;
      end
      r_cpu_rvalid <= w_cpu_gnt & ~r_we;
      r_dbg_rvalid <= w_dbg_gnt & ~r_we;
      if (w_m_valid && (r_busy_cnt != {CNT_WIDTH{1'b1}})) begin
        r_busy_cnt <= r_busy_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.o_cpu_gnt    = w_cpu_gnt;
  assign bus.o_dbg_gnt    = w_dbg_gnt;
  assign bus.o_cpu_rvalid = r_cpu_rvalid;
  assign bus.o_dbg_rvalid = r_dbg_rvalid;
  assign bus.o_rdata      = r_rdata;
  assign bus.o_m_valid    = w_m_valid;
  assign bus.o_m_we       = r_we;
  assign bus.o_m_addr     = r_addr;
  assign bus.o_m_wdata    = r_wdata;
  assign bus.o_busy_cnt   = r_busy_cnt;

endmodule

`default_nettype wire
